// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one cacheline-adapter port between the icache (read-only)
// and the dcache (read/write). Round-robin between the two sides, one 256-bit line
// transaction outstanding at a time. The address and write data are captured at
// grant, so memory sees stable values until pmem_resp.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_pmem_*                  icache side: read request, address, rdata/resp back
//   d_pmem_*                  dcache side: read/write request, address, wdata, rdata/resp back
//   pmem_read/write           shared request to the cacheline adapter
//   pmem_address/wdata        registered address and write data for the shared port
//   pmem_rdata, pmem_resp     line data and completion pulse from memory
module pmem_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        StIdle,
        StServeI,
        StServeDRd,
        StServeDWr
    } state_e;

    state_e            state_q;
    logic              last_grant_q;  // 0 = icache, 1 = dcache
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic i_req;
    logic d_req;
    logic grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // On a tie the side that did not win last time gets the grant.
    assign grant_d = d_req & (~i_req | ~last_grant_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_req || d_req) begin
                        last_grant_q <= grant_d;
                        if (grant_d) begin
                            addr_q  <= d_pmem_address;
                            wdata_q <= d_pmem_wdata;
                            // Read and write together is illegal; write takes priority.
                            state_q <= d_pmem_write ? StServeDWr : StServeDRd;
                        end else begin
                            addr_q  <= i_pmem_address;
                            state_q <= StServeI;
                        end
                    end
                end
                StServeI, StServeDRd, StServeDWr: begin
                    if (pmem_resp) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Simulation-only check of the dcache protocol.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(d_pmem_read && d_pmem_write))
            else $warning("pmem_arbiter: dcache read and write asserted together, write wins");
        end
    end

    logic serve_i;
    logic serve_d;

    assign serve_i = (state_q == StServeI);
    assign serve_d = (state_q == StServeDRd) || (state_q == StServeDWr);

    // Shared-port controls are silenced while reset is held, even mid-transaction.
    assign pmem_read    = ~rst & (serve_i | (state_q == StServeDRd));
    assign pmem_write   = ~rst & (state_q == StServeDWr);
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Read data is broadcast; each cache qualifies it with its own resp.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign i_pmem_resp  = ~rst & serve_i & pmem_resp;
    assign d_pmem_resp  = ~rst & serve_d & pmem_resp;

endmodule
